// File: rtl/dbus_pkg.sv
// Shared address map and decode for the data-bus responder.
package dbus_pkg;

    localparam logic [31:0] IO_BASE   = 32'hFFFF_F000;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_TCTRL = 12'h020;
    localparam logic [11:0] OFF_TCNT  = 12'h024;
    localparam logic [11:0] OFF_TCMP  = 12'h028;
    localparam logic [11:0] OFF_TSTAT = 12'h02C;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TIMER,
        SEL_NONE
    } dbus_sel_t;

    // Byte-lane bits [1:0] never take part in the I/O match.
    function automatic dbus_sel_t dbus_decode(input logic [31:0] addr,
                                              input logic [32:0] ram_bytes,
                                              input logic        timer_present);
        dbus_sel_t sel;
        sel = SEL_NONE;
        if ({1'b0, addr} < ram_bytes) begin
            sel = SEL_RAM;
        end else if (addr[31:12] == IO_BASE[31:12]) begin
            if (addr[11:2] == OFF_LED[11:2])
                sel = SEL_LED;
            else if (addr[11:2] == OFF_SW[11:2])
                sel = SEL_SW;
            else if (timer_present && addr[11:4] == OFF_TCTRL[11:4])
                sel = SEL_TIMER;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dbus_timer.sv
// Prescaled compare timer: TCTRL/TCNT/TCMP/TSTAT behind a word-select port.
module dbus_timer
    import dbus_pkg::*;
#(
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [15:0] PRE_LAST = 16'(TIMER_DIV - 1);

    logic        en;
    logic        flag;
    logic [15:0] pre;
    logic [31:0] cnt;
    logic [31:0] cmp;
    logic        tick;
    logic        cnt_wr;
    logic        hit;

    assign tick   = en && (pre == PRE_LAST);
    assign cnt_wr = we && (addr == OFF_TCNT[3:2]);
    // A software TCNT write swallows a coincident tick, including its hit.
    assign hit    = tick && !cnt_wr && (cnt == cmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            en   <= 1'b0;
            flag <= 1'b0;
            pre  <= 16'd0;
            cnt  <= 32'd0;
            cmp  <= 32'hFFFF_FFFF;
        end else begin
            if (!en || tick)
                pre <= 16'd0;
            else
                pre <= pre + 16'd1;

            if (cnt_wr)
                cnt <= wdata;
            else if (hit)
                cnt <= 32'd0;
            else if (tick)
                cnt <= cnt + 32'd1;

            if (hit)
                flag <= 1'b1;
            else if (we && addr == OFF_TSTAT[3:2] && wdata[0])
                flag <= 1'b0;

            if (we && addr == OFF_TCMP[3:2])
                cmp <= wdata;
            if (we && addr == OFF_TCTRL[3:2])
                en <= wdata[0];
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            OFF_TCTRL[3:2]: rdata = {31'd0, en};
            OFF_TCNT[3:2]:  rdata = cnt;
            OFF_TCMP[3:2]:  rdata = cmp;
            default:        rdata = {31'd0, flag};
        endcase
    end

    assign irq = flag;

endmodule

// File: rtl/dbus_resp.sv
// Data-bus responder: word RAM, LED/switch I/O and optional timer.
// Timer present only when DBUS_TIMER_EN is defined.
module dbus_resp
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned TIMER_DIV   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [31:0] rdata_o,
    input  logic [23:0] sw_i,
    output logic [23:0] led_o,
    output logic        irq_o
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
`ifdef DBUS_TIMER_EN
    localparam logic        TIMER_PRESENT = 1'b1;
`else
    localparam logic        TIMER_PRESENT = 1'b0;
`endif

    logic [31:0] mem [DEPTH_WORDS];
    logic [23:0] led_q;
    logic [31:0] timer_rdata;
    dbus_sel_t   sel;

    assign sel = dbus_decode(addr_i, RAM_BYTES, TIMER_PRESENT);

    // RAM ignores rst so its contents survive a core reset.
    always_ff @(posedge clk) begin
        if (we_i && sel == SEL_RAM)
            mem[addr_i[AW+1:2]] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst)
            led_q <= 24'd0;
        else if (we_i && sel == SEL_LED)
            led_q <= wdata_i[23:0];
    end

    assign led_o = led_q;

`ifdef DBUS_TIMER_EN
    dbus_timer #(
        .TIMER_DIV(TIMER_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .we   (we_i && sel == SEL_TIMER),
        .addr (addr_i[3:2]),
        .wdata(wdata_i),
        .rdata(timer_rdata),
        .irq  (irq_o)
    );
`else
    logic unused_timer_div;
    assign unused_timer_div = ^TIMER_DIV;
    assign timer_rdata      = 32'd0;
    assign irq_o            = 1'b0;
`endif

    always_comb begin
        rdata_o = 32'd0;
        case (sel)
            SEL_RAM:   rdata_o = mem[addr_i[AW+1:2]];
            SEL_LED:   rdata_o = {8'd0, led_q};
            SEL_SW:    rdata_o = {8'd0, sw_i};
            SEL_TIMER: rdata_o = timer_rdata;
            default:   rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_dbus_resp.sv
// Bench for dbus_resp: directed scenarios plus random traffic against a behavioural model.
module tb_dbus_resp;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned DIV   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [23:0] sw;
    logic [23:0] led;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    bit check_on = 1'b0;

    dbus_resp #(.DEPTH_WORDS(DEPTH), .TIMER_DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr_i (addr),
        .wdata_i(wdata),
        .we_i   (we),
        .rdata_o(rdata),
        .sw_i   (sw),
        .led_o  (led),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [23:0] m_led;
    bit          m_en;
    bit          m_flag;
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    int unsigned m_phase;   // cycles spent enabled since enable/reset

    function automatic bit is_io(input logic [31:0] a);
        return a[31:12] == 20'hFFFFF;
    endfunction

    function automatic logic [11:0] io_off(input logic [31:0] a);
        return {a[11:2], 2'b00};
    endfunction

    function automatic bit tick_next();
        return m_en && ((m_phase % DIV) == DIV - 1);
    endfunction

    function automatic bit hit_next();
        return tick_next() && (m_cnt == m_cmp);
    endfunction

    always @(posedge clk) begin
        bit t;
        bit h;
        bit cw;
        if (we && ({1'b0, addr} < 33'(DEPTH * 4))) begin
            m_mem[addr[7:2]]   = wdata;
            m_known[addr[7:2]] = 1'b1;
        end
        if (rst) begin
            m_led   = 24'd0;
            m_en    = 1'b0;
            m_flag  = 1'b0;
            m_cnt   = 32'd0;
            m_cmp   = 32'hFFFF_FFFF;
            m_phase = 0;
        end else begin
            if (we && is_io(addr) && io_off(addr) == 12'h060)
                m_led = wdata[23:0];
`ifdef DBUS_TIMER_EN
            t  = tick_next();
            cw = we && is_io(addr) && io_off(addr) == 12'h024;
            h  = t && !cw && (m_cnt == m_cmp);
            if (cw)
                m_cnt = wdata;
            else if (t)
                m_cnt = h ? 32'd0 : m_cnt + 32'd1;
            if (h)
                m_flag = 1'b1;
            else if (we && is_io(addr) && io_off(addr) == 12'h02C && wdata[0])
                m_flag = 1'b0;
            m_phase = m_en ? m_phase + 1 : 0;
            if (we && is_io(addr) && io_off(addr) == 12'h028)
                m_cmp = wdata;
            if (we && is_io(addr) && io_off(addr) == 12'h020)
                m_en = wdata[0];
`else
            t  = 1'b0;
            h  = 1'b0;
            cw = 1'b0;
`endif
        end
    end

    function automatic void model_read(input logic [31:0] a, output logic [31:0] v,
                                       output bit known);
        known = 1'b1;
        v     = 32'd0;
        if ({1'b0, a} < 33'(DEPTH * 4)) begin
            known = m_known[a[7:2]];
            v     = m_mem[a[7:2]];
        end else if (is_io(a)) begin
            case (io_off(a))
                12'h060: v = {8'd0, m_led};
                12'h070: v = {8'd0, sw};
`ifdef DBUS_TIMER_EN
                12'h020: v = {31'd0, m_en};
                12'h024: v = m_cnt;
                12'h028: v = m_cmp;
                12'h02C: v = {31'd0, m_flag};
`endif
                default: v = 32'd0;
            endcase
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] ev;
        bit          kn;
        if (check_on) begin
            model_read(addr, ev, kn);
            if (kn)
                chk("model_rdata", rdata, ev);
            chk("model_led", {8'd0, led}, {8'd0, m_led});
`ifdef DBUS_TIMER_EN
            chk("model_irq", {31'd0, irq}, {31'd0, m_flag});
`else
            chk("model_irq", {31'd0, irq}, 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        @(posedge clk);
        #1;
        rst   = r;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, 1'b0, a, 32'd0);
        @(negedge clk);
        chk(name, rdata, exp);
    endtask

    initial begin
        int first_irq;
        bit found;
        rst   = 1'b1;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        sw    = 24'd0;
        repeat (2) @(posedge clk);
        #1;
        check_on = 1'b1;
        @(negedge clk);
        chk("reset_led", {8'd0, led}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);

        // RAM
        drive(1'b0, 1'b1, 32'h0000_0014, 32'h1122_3344);
        drive(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        peek("ram_rd_10", 32'h0000_0010, 32'hDEAD_BEEF);
        peek("ram_rd_13", 32'h0000_0013, 32'hDEAD_BEEF);
        peek("ram_rd_14", 32'h0000_0014, 32'h1122_3344);

        // LED / SW
        drive(1'b0, 1'b1, 32'hFFFF_F060, 32'hFF12_3456);
        peek("led_rd", 32'hFFFF_F060, 32'h0012_3456);
        chk("led_out", {8'd0, led}, 32'h0012_3456);
        sw = 24'hA5A5A5;
        peek("sw_rd", 32'hFFFF_F070, 32'h00A5_A5A5);
        drive(1'b0, 1'b1, 32'hFFFF_F070, 32'h0000_0000);
        peek("sw_after_wr", 32'hFFFF_F070, 32'h00A5_A5A5);

        // unmapped
        drive(1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678);
        peek("unmapped_rd", 32'h8000_0000, 32'd0);

`ifdef DBUS_TIMER_EN
        drive(1'b0, 1'b1, 32'hFFFF_F028, 32'd2);
        drive(1'b0, 1'b1, 32'hFFFF_F020, 32'd1);
        drive(1'b0, 1'b0, 32'hFFFF_F024, 32'd0);
        first_irq = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (irq && first_irq == 0) first_irq = k;
            if (k == 4)  chk("tcnt_at_4", rdata, 32'd1);
            if (k == 8)  chk("tcnt_at_8", rdata, 32'd2);
            if (k == 12) chk("tcnt_at_12", rdata, 32'd0);
        end
        chk("irq_rise_cycle", first_irq, 32'd12);
        drive(1'b0, 1'b1, 32'hFFFF_F02C, 32'd1);
        drive(1'b0, 1'b0, 32'hFFFF_F024, 32'd0);
        @(negedge clk);
        chk("irq_after_w1c", {31'd0, irq}, 32'd0);

        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (hit_next()) found = 1'b1;
        end
        if (!found) chk("wait_hit_timeout", 32'd0, 32'd1);
        we = 1'b1; addr = 32'hFFFF_F02C; wdata = 32'd1;
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        chk("w1c_vs_hit", {31'd0, irq}, 32'd1);

        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (tick_next() && !hit_next()) found = 1'b1;
        end
        if (!found) chk("wait_tick_timeout", 32'd0, 32'd1);
        we = 1'b1; addr = 32'hFFFF_F024; wdata = 32'd100;
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        chk("tcnt_wr_vs_tick", rdata, 32'd100);
`else
        peek("tcnt_absent", 32'hFFFF_F024, 32'd0);
        chk("irq_absent", {31'd0, irq}, 32'd0);
`endif

        // reset mid-count with coincident RAM write
        drive(1'b1, 1'b1, 32'h0000_0018, 32'h5555_AAAA);
        drive(1'b0, 1'b0, 32'hFFFF_F060, 32'd0);
        @(negedge clk);
        chk("rst_led", {8'd0, led}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
`ifdef DBUS_TIMER_EN
        peek("rst_tcnt", 32'hFFFF_F024, 32'd0);
        peek("rst_tcmp", 32'hFFFF_F028, 32'hFFFF_FFFF);
`endif
        peek("rst_ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);
        peek("rst_ram_wr", 32'h0000_0018, 32'h5555_AAAA);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            logic        r;
            d = $urandom;
            case ($urandom_range(0, 10))
                0, 1, 2: a = ($urandom_range(0, DEPTH - 1) << 2);
                3: a = 32'hFFFF_F060;
                4: a = 32'hFFFF_F070;
                5: begin a = 32'hFFFF_F020; if ($urandom_range(0, 4) != 0) d[0] = 1'b1; end
                6: begin a = 32'hFFFF_F024; d = $urandom_range(0, 12); end
                7: begin a = 32'hFFFF_F028; d = $urandom_range(0, 12); end
                8: a = 32'hFFFF_F02C;
                9: a = 32'hFFFF_F000 | ($urandom_range(0, 1023) << 2);
                default: a = $urandom;
            endcase
            a = a | $urandom_range(0, 3);
            w = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) sw = 24'($urandom);
            drive(r, w, a, d);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
